signnarrow_pack: RTL

- Store-path counterpart to the sign/zero extender: narrows 32-bit register values to 16 bits, signed or unsigned, for halfword stores to data memory.
- Detects values that do not fit in 16 bits. Either saturates them or truncates them.
- Optionally packs two consecutive narrowed halfwords into one 32-bit memory word.
- Sits between the register-file read port and the data-memory write buffer. Valid/ready on both sides.

---
 rtl/signnarrow_pkg.sv | 25 ++
 rtl/signnarrow_core.sv | 64 ++++++
 rtl/signnarrow_pack.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/signnarrow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : signnarrow_pkg
// Description : Shared encodings and constants for the store-path narrower.
// Revision    : 1.0 - initial release
// ============================================================================
package signnarrow_pkg;

  // Pack state: EMPTY holds nothing, HALF holds the low half of a pair
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_e;

  // narrowSel encodings
  localparam logic NARROW_SIGNED   = 1'b0;
  localparam logic NARROW_UNSIGNED = 1'b1;

  // Saturation values for a 16-bit halfword
  localparam logic [15:0] SAT_SMAX = 16'h7FFF;
  localparam logic [15:0] SAT_SMIN = 16'h8000;
  localparam logic [15:0] SAT_UMAX = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/signnarrow_core.sv
`default_nettype none
// ============================================================================
// Module      : signnarrow_core
// Description : Combinational narrowing of one word to OUT_W bits with
//               overflow detection and optional saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module signnarrow_core
  import signnarrow_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic             narrowSel,
  input  logic             sat_en,
  output logic [OUT_W-1:0] n,
  output logic             ovf
);

  logic [OUT_W-1:0]     w_smax;
  logic [OUT_W-1:0]     w_smin;
  logic [OUT_W-1:0]     w_umax;
  logic [IN_W-OUT_W:0]  w_sgn_bits;
  logic                 w_sfit;
  logic                 w_ufit;
  logic                 w_fit;

  // The halfword store path uses the shared constants; other widths derive them
  if (OUT_W == 16) begin : g_sat16
    assign w_smax = SAT_SMAX;
    assign w_smin = SAT_SMIN;
    assign w_umax = SAT_UMAX;
  end else begin : g_satgen
    assign w_smax = {1'b0, {(OUT_W-1){1'b1}}};
    assign w_smin = {1'b1, {(OUT_W-1){1'b0}}};
    assign w_umax = {OUT_W{1'b1}};
  end

  // Signed fit: every bit from the MSB down to the new sign bit agrees
  assign w_sgn_bits = in_data[IN_W-1:OUT_W-1];
  assign w_sfit     = (&w_sgn_bits) | ~(|w_sgn_bits);
  // Unsigned fit: nothing above the narrowed field
  assign w_ufit     = ~(|in_data[IN_W-1:OUT_W]);
  assign w_fit      = (narrowSel == NARROW_UNSIGNED) ? w_ufit : w_sfit;

  // Truncate by default; replace with the clamp value on saturating overflow
  always_comb begin
    n   = in_data[OUT_W-1:0];
    ovf = 1'b0;
    if (!w_fit) begin
      ovf = 1'b1;
      if (sat_en) begin
        if (narrowSel == NARROW_UNSIGNED) begin
          n = w_umax;
        end else begin
          n = in_data[IN_W-1] ? w_smin : w_smax;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/signnarrow_pack.sv
`default_nettype none
// ============================================================================
// Module      : signnarrow_pack
// Description : Narrows register words to halfwords for memory stores,
//               optionally packing pairs into one word, with overflow stats.
// Revision    : 1.0 - initial release
// ============================================================================
module signnarrow_pack
  import signnarrow_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic               narrowSel,
  input  logic               sat_en,
  input  logic               pack_en,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*OUT_W-1:0] out_data,
  output logic [1:0]         out_cnt,
  output logic [1:0]         out_ovf,
  input  logic               ovf_clr,
  output logic               ovf_sticky,
  output logic [CNT_W-1:0]   ovf_count
);

  pack_state_e          r_state;
  logic [OUT_W-1:0]     r_hold;
  logic                 r_hold_ovf;
  logic                 r_out_valid;
  logic [2*OUT_W-1:0]   r_out_data;
  logic [1:0]           r_out_cnt;
  logic [1:0]           r_out_ovf;
  logic                 r_ovf_sticky;
  logic [CNT_W-1:0]     r_ovf_count;

  logic [OUT_W-1:0]     w_n;
  logic                 w_ovf;
  logic                 w_in_ready;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_out_free;
  logic                 w_ovf_fire;

  signnarrow_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_data   (in_data),
    .narrowSel (narrowSel),
    .sat_en    (sat_en),
    .n         (w_n),
    .ovf       (w_ovf)
  );

  assign w_out_free = ~r_out_valid | out_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_in_fire  = in_valid & w_in_ready;
  assign w_ovf_fire = w_in_fire & w_ovf;

  // A first half only touches the hold register, so it may enter under a stall
  always_comb begin
    w_in_ready = w_out_free;
    if (r_state == EMPTY && pack_en) begin
      w_in_ready = 1'b1;
    end
  end

  // Pack FSM with hold register and registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_hold      <= '0;
      r_hold_ovf  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cnt   <= 2'd0;
      r_out_ovf   <= 2'b00;
    end else begin
      if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            if (pack_en) begin
              r_hold     <= w_n;
              r_hold_ovf <= w_ovf;
              r_state    <= HALF;
            end else begin
              r_out_valid <= 1'b1;
              r_out_data  <= {{OUT_W{1'b0}}, w_n};
              r_out_cnt   <= 2'd1;
              r_out_ovf   <= {1'b0, w_ovf};
            end
          end
        end
        HALF: begin
          // A completing word takes priority; flush then has nothing left to do
          if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {w_n, r_hold};
            r_out_cnt   <= 2'd2;
            r_out_ovf   <= {w_ovf, r_hold_ovf};
            r_state     <= EMPTY;
          end else if (flush && w_out_free) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {{OUT_W{1'b0}}, r_hold};
            r_out_cnt   <= 2'd1;
            r_out_ovf   <= {1'b0, r_hold_ovf};
            r_state     <= EMPTY;
          end
        end
      endcase
    end
  end

  // Sticky flag and saturating counter; a clear still counts a same-cycle overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= '0;
    end else if (ovf_clr) begin
      r_ovf_sticky <= w_ovf_fire;
      r_ovf_count  <= {{(CNT_W-1){1'b0}}, w_ovf_fire};
    end else if (w_ovf_fire) begin
      r_ovf_sticky <= 1'b1;
      if (r_ovf_count != {CNT_W{1'b1}}) begin
        r_ovf_count <= r_ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_cnt    = r_out_cnt;
  assign out_ovf    = r_out_ovf;
  assign ovf_sticky = r_ovf_sticky;
  assign ovf_count  = r_ovf_count;

endmodule
`default_nettype wire
